// File: rtl/morse_pkg.sv
// Shared types and default timing for the Morse entry front-end.
// Defaults assume a 100 MHz clock.
package morse_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    GAP    = 2'd2,
    COMMIT = 2'd3
  } state_e;

  localparam int MAX_ELEM             = 5;
  localparam int DEF_DEBOUNCE_CYC     = 1000000;
  localparam int DEF_DASH_MIN_CYC     = 30000000;
  localparam int DEF_GAP_CYC          = 80000000;
  localparam int DEF_CNT_W            = 27;

endpackage

// File: rtl/morse_entry_ctrl_debounce.sv
// Two-flop synchroniser plus stability-counter debouncer.
// Emits one-cycle rise/fall pulses on the debounced level.
module morse_entry_ctrl_debounce #(
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int CNT_W        = 27
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d, level_prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == STABLE_LAST) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= raw_i;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      cnt_q        <= cnt_d;
    end
  end

  assign rise_o = level_q & ~level_prev_q;
  assign fall_o = ~level_q & level_prev_q;

endmodule

// File: rtl/morse_entry_ctrl.sv
// Morse key / backspace sequencer: classifies dot/dash presses, assembles
// letters of up to five elements and issues commit or backspace pulses.
module morse_entry_ctrl
  import morse_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
  parameter int DASH_MIN_CYC = DEF_DASH_MIN_CYC,
  parameter int GAP_CYC      = DEF_GAP_CYC,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_raw,
  input  logic       bksp_raw,
  output logic       commit,
  output logic [4:0] sym_bits,
  output logic [2:0] sym_len,
  output logic       bksp,
  output logic       overflow,
  output logic       busy
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DASH_TH  = CNT_W'(DASH_MIN_CYC);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [2:0]       MAX_LEN  = 3'(MAX_ELEM);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  logic key_rise, key_fall, bk_rise, bk_fall_unused;

  morse_entry_ctrl_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_key_db (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (key_raw),
    .rise_o (key_rise),
    .fall_o (key_fall)
  );

  morse_entry_ctrl_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .CNT_W(CNT_W)) u_bksp_db (
    .clk    (clk),
    .rst    (rst),
    .raw_i  (bksp_raw),
    .rise_o (bk_rise),
    .fall_o (bk_fall_unused)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] dur_q, dur_d, gap_q, gap_d;
  logic [4:0]       acc_bits_q, acc_bits_d, sym_bits_q, sym_bits_d;
  logic [2:0]       acc_len_q, acc_len_d, sym_len_q, sym_len_d;
  logic             commit_q, commit_d, bksp_q, bksp_d;
  logic             pend_q, pend_d, ovf_q, ovf_d;
  logic             busy_w, elem, bk_req, bk_cancel;

  assign busy_w    = (acc_len_q != 3'd0);
  assign elem      = (dur_q >= DASH_TH);
  // In COMMIT the letter is already handed off, so backspace acts as idle.
  assign bk_req    = bk_rise && (!busy_w || state_q == COMMIT);
  assign bk_cancel = bk_rise && busy_w && state_q != COMMIT;

  always_comb begin
    state_d    = state_q;
    dur_d      = dur_q;
    gap_d      = gap_q;
    acc_bits_d = acc_bits_q;
    acc_len_d  = acc_len_q;
    sym_bits_d = sym_bits_q;
    sym_len_d  = sym_len_q;
    commit_d   = 1'b0;
    ovf_d      = 1'b0;
    bksp_d     = 1'b0;
    pend_d     = pend_q;

    case (state_q)
      IDLE: begin
        if (key_rise) begin
          state_d = PRESS;
          dur_d   = '0;
        end
      end
      PRESS: begin
        dur_d = sat_inc(dur_q);
        if (key_fall) begin
          if (acc_len_q < MAX_LEN) begin
            acc_bits_d = acc_bits_q | (5'(elem) << acc_len_q);
            acc_len_d  = acc_len_q + 3'd1;
            gap_d      = '0;
            state_d    = GAP;
          end else begin
            ovf_d      = 1'b1;
            acc_bits_d = '0;
            acc_len_d  = '0;
            state_d    = IDLE;
          end
        end
      end
      GAP: begin
        if (key_rise) begin
          state_d = PRESS;
          dur_d   = '0;
        end else begin
          gap_d = sat_inc(gap_q);
          if (gap_q == GAP_LAST) begin
            state_d    = COMMIT;
            commit_d   = 1'b1;
            sym_bits_d = acc_bits_q;
            sym_len_d  = acc_len_q;
          end
        end
      end
      COMMIT: begin
        acc_bits_d = '0;
        acc_len_d  = '0;
        state_d    = IDLE;
        if (key_rise) begin
          state_d = PRESS;
          dur_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (bk_cancel) begin
      state_d    = IDLE;
      acc_bits_d = '0;
      acc_len_d  = '0;
      commit_d   = 1'b0;
      sym_bits_d = sym_bits_q;
      sym_len_d  = sym_len_q;
    end

    // A backspace colliding with a commit waits one cycle in pend_q.
    if (commit_d) begin
      pend_d = pend_q | bk_req;
    end else begin
      bksp_d = pend_q | bk_req;
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      dur_q      <= '0;
      gap_q      <= '0;
      acc_bits_q <= '0;
      acc_len_q  <= '0;
      sym_bits_q <= '0;
      sym_len_q  <= '0;
      commit_q   <= 1'b0;
      bksp_q     <= 1'b0;
      pend_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dur_q      <= dur_d;
      gap_q      <= gap_d;
      acc_bits_q <= acc_bits_d;
      acc_len_q  <= acc_len_d;
      sym_bits_q <= sym_bits_d;
      sym_len_q  <= sym_len_d;
      commit_q   <= commit_d;
      bksp_q     <= bksp_d;
      pend_q     <= pend_d;
      ovf_q      <= ovf_d;
    end
  end

  assign commit   = commit_q;
  assign sym_bits = sym_bits_q;
  assign sym_len  = sym_len_q;
  assign bksp     = bksp_q;
  assign overflow = ovf_q;
  assign busy     = busy_w;

endmodule

// File: doc/morse_entry_ctrl.md
Name: morse_entry_ctrl

Overview:
- Front-end sequencer for the Morse decoder display path.
- Turns a raw Morse key and a raw backspace button into the two commands the display shift register accepts: one-cycle letter-commit pulses and one-cycle backspace pulses.
- Synchronises and debounces both buttons, times key presses to classify dot or dash, accumulates up to 5 elements, and commits the letter after an inter-letter gap.
- Arbitrates commit against backspace so the display never sees both in one cycle.

Parameters:
- DEBOUNCE_CYC, 1000000: cycles an input must stay stable before its debounced level changes (10 ms at 100 MHz).
- DASH_MIN_CYC, 30000000: press length in cycles at or above which an element is a dash; below it is a dot.
- GAP_CYC, 80000000: key-released cycles after the last element that end the letter.
- CNT_W, 27: width of the duration counters; must hold GAP_CYC.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous, active-high
- key_raw  input  1  Morse key, asynchronous, 1 = pressed
- bksp_raw  input  1  backspace button, asynchronous, 1 = pressed
- commit  output  1  one-cycle pulse: sym_bits/sym_len hold a complete letter
- sym_bits  output  5  element i at bit i (0 = dot, 1 = dash), bit 0 is the first element
- sym_len  output  3  element count of the committed letter, 1..5
- bksp  output  1  one-cycle pulse: delete the last displayed character
- overflow  output  1  one-cycle pulse: a sixth element arrived and the letter was discarded
- busy  output  1  high while a letter is in progress (element count > 0)

Behaviour:
- Reset: all outputs 0, counters 0, state IDLE.
  - rst asserted mid-letter discards the partial letter with no commit.
  - A pending backspace is also discarded.
- Input conditioning:
  - Each raw input passes through a 2-flop synchroniser, then a debouncer.
  - Debounced level changes only after DEBOUNCE_CYC consecutive cycles of a differing synchronised value.
  - Edge detect runs on the debounced level.
- IDLE: waits for a key rising edge, then goes to PRESS with the duration counter cleared.
- PRESS:
  - Duration counter increments each cycle and saturates at all-ones.
  - On key falling edge: element = (count >= DASH_MIN_CYC).
  - If count_len < 5: write the element at bit[count_len], increment count_len, go to GAP.
  - If count_len == 5: pulse overflow, clear bits and len, go to IDLE.
- GAP:
  - Gap counter increments while the key is released.
  - Key rising edge before GAP_CYC: go to PRESS; the letter continues.
  - Gap counter reaching GAP_CYC: go to COMMIT.
- COMMIT (one cycle):
  - Loads sym_bits/sym_len from the accumulator and pulses commit.
  - Clears the accumulator and returns to IDLE.
  - sym_bits/sym_len are registered and hold their value until the next commit.
- Latency:
  - commit asserts exactly GAP_CYC+1 cycles after the debounced falling edge of the last element.
  - End to end this adds 2 sync cycles plus DEBOUNCE_CYC.
- Backspace:
  - Debounced rising edge with busy = 0: bksp pulses for one cycle.
  - Debounced rising edge with busy = 1: cancels the in-progress letter (accumulator cleared, state IDLE). No bksp pulse and no commit.
  - Edge in the same cycle the FSM is in COMMIT: commit wins that cycle; bksp is latched as pending and pulses the next cycle.
  - At most one pending backspace is held; further edges while pending are dropped.
- Invariant: commit and bksp are never high in the same cycle.
- Key pressed while in COMMIT: the rising edge is still honoured; the FSM goes to PRESS on the next cycle with a fresh letter.
- Duration counters are unsigned, CNT_W bits, and saturate rather than wrap.

Decomposition:
- Shared package morse_pkg:
  - state enum IDLE/PRESS/GAP/COMMIT
  - MAX_ELEM = 5
  - default timing constants
- One natural sub-module: debounce, instantiated twice (key and backspace). It holds the synchroniser, stability counter, debounced level and rise/fall pulses.

Test Plan:
Bench overrides: DEBOUNCE_CYC = 4, DASH_MIN_CYC = 20, GAP_CYC = 50.
- Press 10 cycles, release 60 cycles -> single commit, sym_len = 1, sym_bits = 00000 ("E"). commit at debounced fall + 51.
- Presses 10, 30, 10 cycles with 15-cycle gaps, then release -> one commit, sym_len = 3, sym_bits = 00010.
- Six 10-cycle presses with 15-cycle gaps -> overflow pulse on the sixth release, no commit, busy returns to 0.
- bksp_raw held 10 cycles while idle -> exactly one bksp pulse. A 2-cycle glitch on bksp_raw -> no pulse.
- Two elements entered, then backspace edge during GAP -> no commit, no bksp, busy = 0, next letter starts fresh.
- Backspace edge aligned to the COMMIT cycle -> commit at cycle N, bksp at cycle N+1, never both high together.
- rst mid-PRESS -> all outputs 0 immediately. A subsequent full letter commits correctly.
